e_muldiv: RTL and testbench

//  Execute-stage multiply/divide unit with architectural HI/LO registers.

---
 rtl/e_muldiv_if.sv | 21 ++
 rtl/e_muldiv.sv | 145 ++++++++++++++
 tb/tb_e_muldiv.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/e_muldiv_if.sv
// rtl/e_muldiv_if.sv - E-stage operand/result bundle for the multiply/divide unit
interface e_muldiv_if;
  logic [31:0] instr_e;
  logic [31:0] v1_e;
  logic [31:0] v2_e;
  logic        start;
  logic        busy;
  logic [31:0] md_rdata;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output instr_e, v1_e, v2_e,
    input  start, busy, md_rdata, hi, lo
  );

  modport slave (
    input  instr_e, v1_e, v2_e,
    output start, busy, md_rdata, hi, lo
  );
endinterface

// File: rtl/e_muldiv.sv
// rtl/e_muldiv.sv - execute-stage multi-cycle MULT/DIV unit with architectural HI/LO
module e_muldiv #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  e_muldiv_if.slave  md
);

  localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned CW      = $clog2(MAX_LAT + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d;
  logic [31:0]   pend_lo_q, pend_lo_d;
  logic          pend_dz_q, pend_dz_d;

  logic [5:0] opc;
  logic [5:0] fn;
  logic       special;
  logic       is_mult, is_multu, is_div, is_divu;
  logic       is_mfhi, is_mflo, is_mthi, is_mtlo;
  logic       is_md, is_dv;
  logic       issue_ok;
  logic       start_w;
  logic       unused_instr;

  assign opc          = md.instr_e[31:26];
  assign fn           = md.instr_e[5:0];
  assign unused_instr = ^md.instr_e[25:6];
  assign special      = (opc == 6'h00);
  assign is_mfhi      = special && (fn == 6'h10);
  assign is_mthi      = special && (fn == 6'h11);
  assign is_mflo      = special && (fn == 6'h12);
  assign is_mtlo      = special && (fn == 6'h13);
  assign is_mult      = special && (fn == 6'h18);
  assign is_multu     = special && (fn == 6'h19);
  assign is_div       = special && (fn == 6'h1A);
  assign is_divu      = special && (fn == 6'h1B);
  assign is_md        = is_mult | is_multu | is_div | is_divu;
  assign is_dv        = is_div | is_divu;

  // The committing cycle (cnt==1) already frees HI/LO for the next edge, so a
  // new op or an MT write may be accepted there; everything earlier is a hazard.
  assign issue_ok = (cnt_q == '0) || (cnt_q == CW'(1));
  assign start_w  = is_md && issue_ok;

  logic [63:0] mul_s, mul_u;
  assign mul_s = {{32{md.v1_e[31]}}, md.v1_e} * {{32{md.v2_e[31]}}, md.v2_e};
  assign mul_u = {32'h0, md.v1_e} * {32'h0, md.v2_e};

  // Signed divide is done on magnitudes so 0x80000000 / -1 falls out naturally.
  logic        a_neg, b_neg, div_zero;
  logic [31:0] mag_a, mag_b, safe_b;
  logic [31:0] q_mag, r_mag, quot, rem;
  assign a_neg    = is_div && md.v1_e[31];
  assign b_neg    = is_div && md.v2_e[31];
  assign mag_a    = a_neg ? (32'h0 - md.v1_e) : md.v1_e;
  assign mag_b    = b_neg ? (32'h0 - md.v2_e) : md.v2_e;
  assign div_zero = (md.v2_e == 32'h0);
  assign safe_b   = div_zero ? 32'h1 : mag_b;
  assign q_mag    = mag_a / safe_b;
  assign r_mag    = mag_a % safe_b;
  assign quot     = (a_neg ^ b_neg) ? (32'h0 - q_mag) : q_mag;
  assign rem      = a_neg ? (32'h0 - r_mag) : r_mag;

  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_dz_d = pend_dz_q;

    if (state_q == S_RUN) begin
      cnt_d = cnt_q - CW'(1);
      if ((cnt_q == CW'(1)) && !pend_dz_q) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end

    if (start_w) begin
      cnt_d     = is_dv ? CW'(DIV_LAT) : CW'(MULT_LAT);
      pend_dz_d = is_dv && div_zero;
      if (is_dv) begin
        pend_hi_d = rem;
        pend_lo_d = quot;
      end else if (is_mult) begin
        pend_hi_d = mul_s[63:32];
        pend_lo_d = mul_s[31:0];
      end else begin
        pend_hi_d = mul_u[63:32];
        pend_lo_d = mul_u[31:0];
      end
    end

    // MT writes land after the commit so they win over it on the same edge.
    if (issue_ok && is_mthi) hi_d = md.v1_e;
    if (issue_ok && is_mtlo) lo_d = md.v1_e;

    state_d = (cnt_d != '0) ? S_RUN : S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= 32'h0;
      lo_q      <= 32'h0;
      pend_hi_q <= 32'h0;
      pend_lo_q <= 32'h0;
      pend_dz_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_dz_q <= pend_dz_d;
    end
  end

  always_comb begin
    md.md_rdata = 32'h0;
    if (is_mfhi) md.md_rdata = hi_q;
    else if (is_mflo) md.md_rdata = lo_q;
  end

  assign md.start = start_w;
  assign md.busy  = (state_q == S_RUN);
  assign md.hi    = hi_q;
  assign md.lo    = lo_q;

endmodule

// File: tb/tb_e_muldiv.sv
// tb/tb_e_muldiv.sv - self-checking bench for e_muldiv against a cycle-indexed HI/LO model
module tb_e_muldiv;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic clk;
  logic reset_n;
  e_muldiv_if mif ();

  e_muldiv #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .md      (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model: HI/LO plus one pending result tagged with the edge number it lands on.
  int          n_edge      = 0;
  int          commit_edge = 0;
  bit          pending     = 1'b0;
  bit          p_dz        = 1'b0;
  logic [31:0] p_hi, p_lo;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;

  function automatic logic [31:0] mk(input logic [5:0] f);
    return {6'h00, 5'd4, 5'd5, 5'd0, 5'd0, f};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                      input logic rst_n = 1'b1);
    logic [5:0]  f;
    bit          sp, md_op, dv, can_issue, exp_start, exp_busy;
    logic [31:0] exp_rd;
    longint      sa, sb, q, r, p;
    longint unsigned pu;
    int          e;
    f        = ins[5:0];
    sp       = (ins[31:26] == 6'h00);
    md_op    = sp && (f == F_MULT || f == F_MULTU || f == F_DIV || f == F_DIVU);
    dv       = sp && (f == F_DIV || f == F_DIVU);
    can_issue = (n_edge + 1 >= commit_edge);
    exp_start = md_op && can_issue;
    exp_busy  = (n_edge < commit_edge);
    exp_rd    = (sp && f == F_MFHI) ? m_hi : (sp && f == F_MFLO) ? m_lo : 32'h0;

    mif.instr_e = ins;
    mif.v1_e    = a;
    mif.v2_e    = b;
    reset_n     = rst_n;
    #1;
    if (chk_en) begin
      chk("start", {31'h0, mif.start}, {31'h0, exp_start});
      chk("busy", {31'h0, mif.busy}, {31'h0, exp_busy});
      chk("md_rdata", mif.md_rdata, exp_rd);
      chk("hi", mif.hi, m_hi);
      chk("lo", mif.lo, m_lo);
    end
    @(posedge clk);
    e = n_edge + 1;
    if (pending && e == commit_edge) begin
      if (!p_dz) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
      pending = 1'b0;
    end
    if (exp_start) begin
      p_dz = dv && (b == 32'h0);
      if (f == F_MULT) begin
        p = longint'($signed(a)) * longint'($signed(b));
        p_hi = p[63:32];
        p_lo = p[31:0];
      end else if (f == F_MULTU) begin
        pu = longint'({32'h0, a}) * longint'({32'h0, b});
        p_hi = pu[63:32];
        p_lo = pu[31:0];
      end else if (f == F_DIV && !p_dz) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q = sa / sb;
        r = sa % sb;
        p_hi = r[31:0];
        p_lo = q[31:0];
      end else if (!p_dz) begin
        p_hi = a % b;
        p_lo = a / b;
      end
      pending     = 1'b1;
      commit_edge = e + (dv ? DIV_LAT : MULT_LAT);
    end
    if (can_issue && sp && f == F_MTHI) m_hi = a;
    if (can_issue && sp && f == F_MTLO) m_lo = a;
    if (!rst_n) begin
      m_hi = 32'h0;
      m_lo = 32'h0;
      pending = 1'b0;
      commit_edge = 0;
    end
    n_edge = e;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] ins, a, b;
    logic [5:0]  fsel [10];
    fsel = '{F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MFLO, F_MTHI, F_MTLO, F_DIV, F_MULT};

    mif.instr_e = 32'h0;
    mif.v1_e    = 32'h0;
    mif.v2_e    = 32'h0;
    reset_n     = 1'b0;

    step(32'h0, 32'h0, 32'h0, 1'b0);
    chk_en = 1'b1;
    step(32'h0, 32'h0, 32'h0, 1'b0);
    chk("rst_hi", mif.hi, 32'h0);
    chk("rst_lo", mif.lo, 32'h0);
    chk("rst_busy", {31'h0, mif.busy}, 32'h0);

    step(mk(F_MULT), 32'hFFFFFFFD, 32'd5);
    idle(MULT_LAT);
    chk("mult_hi", mif.hi, 32'hFFFFFFFF);
    chk("mult_lo", mif.lo, 32'hFFFFFFF1);

    step(mk(F_MULTU), 32'hFFFFFFFF, 32'hFFFFFFFF);
    idle(MULT_LAT);
    chk("multu_hi", mif.hi, 32'hFFFFFFFE);
    chk("multu_lo", mif.lo, 32'h00000001);

    step(mk(F_DIV), 32'hFFFFFFF9, 32'd2);
    idle(DIV_LAT);
    chk("div_lo", mif.lo, 32'hFFFFFFFD);
    chk("div_hi", mif.hi, 32'hFFFFFFFF);

    step(mk(F_DIVU), 32'd7, 32'd2);
    idle(DIV_LAT);
    chk("divu_lo", mif.lo, 32'd3);
    chk("divu_hi", mif.hi, 32'd1);

    step(mk(F_DIV), 32'h80000000, 32'hFFFFFFFF);
    idle(DIV_LAT);
    chk("ovf_lo", mif.lo, 32'h80000000);
    chk("ovf_hi", mif.hi, 32'h0);

    step(mk(F_MTHI), 32'h1234, 32'h0);
    step(mk(F_DIV), 32'd99, 32'h0);
    idle(DIV_LAT - 1);
    chk("dz_busy_last", {31'h0, mif.busy}, 32'h1);
    idle(1);
    chk("dz_busy_end", {31'h0, mif.busy}, 32'h0);
    chk("dz_hi", mif.hi, 32'h1234);

    step(mk(F_MULT), 32'd2, 32'd3);
    step(mk(F_MTLO), 32'hDEAD, 32'h0);
    chk("mt_busy_lo", mif.lo, 32'h80000000);
    step(mk(F_MULTU), 32'd9, 32'd9);
    idle(MULT_LAT - 2);
    chk("mult2_lo", mif.lo, 32'd6);
    step(mk(F_MFHI), 32'h0, 32'h0);
    chk("mfhi_hi", mif.hi, 32'h0);

    step(mk(F_MULT), 32'd7, 32'd9);
    step(32'h0, 32'h0, 32'h0);
    step(32'h0, 32'h0, 32'h0, 1'b0);
    chk("midrst_busy", {31'h0, mif.busy}, 32'h0);
    chk("midrst_hi", mif.hi, 32'h0);
    idle(MULT_LAT + 1);
    chk("midrst_lo", mif.lo, 32'h0);

    step(mk(F_MULT), 32'd3, 32'd4);
    idle(MULT_LAT - 1);
    step(mk(F_MULT), 32'd5, 32'd6);
    chk("b2b_first", mif.lo, 32'd12);
    idle(MULT_LAT - 1);
    chk("b2b_busy", {31'h0, mif.busy}, 32'h1);
    idle(1);
    chk("b2b_second", mif.lo, 32'd30);
    chk("b2b_idle", {31'h0, mif.busy}, 32'h0);

    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: ins = 32'h0;
        1: ins = {6'h23, 26'($urandom)};
        default: ins = mk(fsel[$urandom_range(0, 9)]);
      endcase
      case ($urandom_range(0, 3))
        0: a = 32'h80000000;
        1: a = $urandom_range(0, 20);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: b = 32'h0;
        1: b = 32'hFFFFFFFF;
        2: b = $urandom_range(1, 9);
        default: b = $urandom;
      endcase
      step(ins, a, b, ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1);
    end
    idle(DIV_LAT + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
